// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
// Ports: clk, rst (sync, active-high), start, funct3, rs1_data, rs2_data,
//   rd_addr in; busy, done, wr_en, wr_addr, wr_data (register-file write) out.
// Optional: define MULDIV_EARLY_OUT_EN to skip iteration on trivial cases.
module rv_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [4:0]       rd_addr,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: product high half / partial remainder
  logic [WIDTH-1:0] acc_q, acc_d;
  // lo: multiplier then product low half / dividend then quotient
  logic [WIDTH-1:0] lo_q, lo_d;
  // opa: multiplicand / divisor magnitude
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             divz_q, divz_d;
  logic             done_q, done_d;
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic             a_sgn, b_sgn, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_sgn = rs1_data[WIDTH-1] &
                 (funct3 == 3'b001 || funct3 == 3'b010 ||
                  funct3 == 3'b100 || funct3 == 3'b110);
  assign b_sgn = rs2_data[WIDTH-1] &
                 (funct3 == 3'b001 || funct3 == 3'b100 ||
                  funct3 == 3'b110);
  assign a_mag  = a_sgn ? -rs1_data : rs1_data;
  assign b_mag  = b_sgn ? -rs2_data : rs2_data;
  assign b_zero = (rs2_data == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic             early;
  logic [WIDTH-1:0] early_acc, early_lo;
  logic             e_mz, e_dz, e_ovf, e_small;
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    e_mz    = ~funct3[2] & ((rs1_data == '0) | b_zero);
    e_dz    = funct3[2] & b_zero;
    e_ovf   = funct3[2] & ~funct3[0] &
              (rs1_data == MINV) & (rs2_data == '1);
    e_small = funct3[2] & (a_mag < b_mag);
    early   = e_mz | e_dz | e_ovf | e_small;
    early_acc = (e_dz | e_small) ? a_mag : '0;
    early_lo  = e_dz ? '1 : (e_ovf ? a_mag : '0);
  end
`endif

  // Shift-add step: conditional add, then shift {acc,lo} right.
  logic [WIDTH:0]   add;
  assign add = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opa_q : '0)};

  // Restoring step: shift in next dividend bit, trial subtract.
  logic [WIDTH:0]   sh;
  logic             ge;
  logic [WIDTH-1:0] sub;
  assign sh  = {acc_q, lo_q[WIDTH-1]};
  assign ge  = (sh >= {1'b0, opa_q});
  assign sub = sh[WIDTH-1:0] - opa_q;

  logic             last;
  assign last = (cnt_q == CW'(WIDTH-1));

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quot, rem, res;

  assign prod   = {acc_q, lo_q};
  assign prod_s = neg_q ? -prod : prod;
  assign quot   = divz_q ? '1 : (neg_q ? -lo_q : lo_q);
  assign rem    = rneg_q ? -acc_q : acc_q;

  always_comb begin
    res = '0;
    case (op_q)
      3'b000:                res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: res = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:        res = quot;
      default:               res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    done_d  = 1'b0;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = funct3;
          rd_d    = rd_addr;
          neg_d   = a_sgn ^ b_sgn;
          rneg_d  = a_sgn;
          divz_d  = funct3[2] & b_zero;
          opa_d   = funct3[2] ? b_mag : a_mag;
          lo_d    = funct3[2] ? a_mag : b_mag;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = funct3[2] ? S_DIV : S_MUL;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            acc_d   = early_acc;
            lo_d    = early_lo;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_MUL: begin
        acc_d = add[WIDTH:1];
        lo_d  = {add[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = S_DONE;
      end
      S_DIV: begin
        if (ge) begin
          acc_d = sub;
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = sh[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        wen_d   = (rd_q != 5'd0);
        waddr_d = rd_q;
        wdata_d = res;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign wr_en   = wen_q;
  assign wr_addr = waddr_q;
  assign wr_data = wdata_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: directed + random checks of rv_muldiv_unit
// against an arithmetic reference model.
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, done, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int compared = 0;
  int mismatched = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  rv_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint p;
    logic [63:0] u;
    int sa, sb, q;
    logic [31:0] r;
    bit ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0;
    case (f)
      3'd0: begin u = {32'b0, a} * {32'b0, b}; r = u[31:0]; end
      3'd1: begin
        p = longint'(sa) * longint'(sb);
        u = p; r = u[63:32];
      end
      3'd2: begin
        p = longint'(sa) * longint'({32'b0, b});
        u = p; r = u[63:32];
      end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; r = u[63:32]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (ovf) r = a;
        else begin q = sa / sb; r = q; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (ovf) r = '0;
        else begin q = sa % sb; r = q; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit trivial(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    logic [31:0] ma, mb;
    bit sg;
    sg = f[2] & ~f[0];
    ma = (sg && a[31]) ? -a : a;
    mb = (sg && b[31]) ? -b : b;
    if (!f[2]) return (a == 0) || (b == 0);
    if (b == 0) return 1'b1;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return ma < mb;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit poke);
    int n, lat;
    bit bsy_ok;
    logic [31:0] exp;
    exp = ref_res(f, a, b);
    lat = (EARLY && trivial(f, a, b)) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    bsy_ok = 1'b1;
    while (!done && n < 100) begin
      if (!busy) bsy_ok = 1'b0;
      if (poke && n == 3) begin
        start = 1'b1;
        funct3 = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_addr = 5'($urandom);
      end
      if (n == 4) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy_while_op"}, 64'(bsy_ok), 64'd1);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " wr_en"}, 64'(wr_en), 64'(rd != 0));
    if (rd != 0) check({tag, " wr_addr"}, 64'(wr_addr), 64'(rd));
    check({tag, " wr_data"}, 64'(wr_data), 64'(exp));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " wr_en_pulse"}, 64'(wr_en), 64'd0);
    check({tag, " wr_data_hold"}, 64'(wr_data), 64'(exp));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    bit          seen;
    rst = 1'b1; start = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst wr_en", 64'(wr_en), 64'd0);
    check("rst wr_addr", 64'(wr_addr), 64'd0);
    check("rst wr_data", 64'(wr_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul7x6", 3'b000, 32'd7, 32'd6, 5'd5, 1'b0);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op("div-7/2", 3'b100, -32'sd7, 32'd2, 5'd4, 1'b0);
    run_op("rem-7/2", 3'b110, -32'sd7, 32'd2, 5'd6, 1'b0);
    run_op("divu100/7", 3'b101, 32'd100, 32'd7, 5'd7, 1'b0);
    run_op("remu100/7", 3'b111, 32'd100, 32'd7, 5'd8, 1'b0);
    run_op("div5/0", 3'b100, 32'd5, 32'd0, 5'd9, 1'b0);
    run_op("rem5/0", 3'b110, 32'd5, 32'd0, 5'd10, 1'b0);
    run_op("div-5/0", 3'b100, -32'sd5, 32'd0, 5'd11, 1'b0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    run_op("divu3/10", 3'b101, 32'd3, 32'd10, 5'd14, 1'b0);
    run_op("remu3/10", 3'b111, 32'd3, 32'd10, 5'd15, 1'b0);
    run_op("mul_zero", 3'b001, 32'd0, 32'hDEAD_BEEF, 5'd16, 1'b0);
    run_op("busy_poke", 3'b101, 32'd1000, 32'd33, 5'd17, 1'b1);
    run_op("rd0", 3'b000, 32'd3, 32'd4, 5'd0, 1'b0);

    // Reset in the middle of an iteration must drop the operation.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b011;
    rs1_data = 32'h0001_2345; rs2_data = 32'h777; rd_addr = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst wr_en", 64'(wr_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || wr_en || busy) seen = 1'b1;
    end
    check("midrst quiet", 64'(seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: ra = '1;
        2: ra = 32'h8000_0000;
        3: ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = '1;
        2: rb = 32'h8000_0000;
        3: rb = $urandom_range(0, 20);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rf, ra, rb,
             5'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
